rpc_burst_splitter: RTL
=======================

RPC_BURST_SPLITTER -- requirements
Module: rpc_burst_splitter

Interface
REQ-001 SHALL have parameter DRAM_ALIGN_POS, default 5: log2 of the maximum DRAM words per command; the cmd_len_o width.
REQ-002 SHALL have parameter DRAM_ADDR_WIDTH, default 20: DRAM word address width (bank + row + column).
REQ-003 SHALL have parameter REQ_LEN_WIDTH, default 12: upstream burst length width, in words minus 1.
REQ-004 SHALL use one clock and a synchronous, active-high reset: clk_i  input  1  clock; rst_i  input  1  synchronous active-high reset.
REQ-005 req_valid_i  input  1  upstream burst request valid.
REQ-006 req_ready_o  output  1  burst request accepted when high together with req_valid_i.
REQ-007 req_is_write_i  input  1  burst direction, 1 = write.
REQ-008 req_addr_i  input  DRAM_ADDR_WIDTH  start DRAM word address.
REQ-009 req_len_i  input  REQ_LEN_WIDTH  burst length in words minus 1.
REQ-010 cmd_valid_o  output  1  command valid toward the controller command port.
REQ-011 cmd_ready_i  input  1  controller command ready.
REQ-012 cmd_is_write_o  output  1  command direction.
REQ-013 cmd_len_o  output  DRAM_ALIGN_POS  command length in words minus 1.
REQ-014 cmd_addr_o  output  DRAM_ADDR_WIDTH  command start word address.
REQ-015 cmd_last_o  output  1  final command of the current burst.
REQ-016 busy_o  output  1  a burst is being split.

Function
REQ-017 SHALL implement the FSM states IDLE and ISSUE; IDLE->ISSUE on req_valid_i&&req_ready_o; ISSUE->IDLE on cmd handshake with cmd_last_o=1.
REQ-018 req_ready_o SHALL be 1 exactly in IDLE; busy_o SHALL be 1 exactly in ISSUE.
REQ-019 On accept: latch direction, addr_q=req_addr_i, rem_q=req_len_i+1 (REQ_LEN_WIDTH+1 bits, no overflow).
REQ-020 Chunk size SHALL be min(rem_q, 2^DRAM_ALIGN_POS - addr_q[DRAM_ALIGN_POS-1:0]); each command SHALL stay within one 2^DRAM_ALIGN_POS-aligned block.
REQ-021 cmd_valid_o SHALL equal busy_o; first cmd_valid_o SHALL rise the cycle after accept (1-cycle latency).
REQ-022 cmd_addr_o=addr_q, cmd_len_o=chunk-1, cmd_last_o=(rem_q==chunk); all are driven from registers/state only, not from cmd_ready_i.
REQ-023 While cmd_valid_o && !cmd_ready_i, all cmd_* outputs SHALL hold stable.
REQ-024 On handshake: addr_q += chunk modulo 2^DRAM_ADDR_WIDTH (wrap from max to 0); rem_q -= chunk.
REQ-025 After the last handshake, the FSM SHALL be in IDLE the next cycle; exactly one bubble cycle separates back-to-back bursts.
REQ-026 req_* inputs SHALL be ignored in ISSUE; cmd_ready_i SHALL be ignored in IDLE.

Reset
REQ-027 When rst_i=1 at a clk_i edge: state=IDLE, addr_q=0, rem_q=0, is_write=0.
REQ-028 Reset outputs: req_ready_o=1, cmd_valid_o=0, busy_o=0, cmd_last_o=0, cmd_len_o=0, cmd_addr_o=0, cmd_is_write_o=0.
REQ-029 Reset mid-burst SHALL abandon the remaining chunks with no further cmd_valid_o.

Structure
REQ-030 rpc_ctrl_pkg SHALL hold burst_req_t (is_write, addr, len) and the default width constants.
REQ-031 The block SHALL have no sub-module; the chunk computation is inline combinational logic.

Verification
REQ-032 Burst addr=0x00000, len=0, cmd_ready_i=1 -> one command: addr 0x00000, len 0, last=1; req_ready_o=1 again 2 cycles after accept.
REQ-033 Burst addr=0x0001C, len=39 -> commands (0x0001C, len 3), (0x00020, len 31), (0x00040, len 3, last).
REQ-034 Burst addr=0x00040, len=31, cmd_ready_i=0 for 5 cycles -> one command (0x00040, len 31, last) held stable and valid all 5 cycles.
REQ-035 Burst addr=0xFFFF0, len=31 -> commands (0xFFFF0, len 15), (0x00000, len 15, last).
REQ-036 Burst len=4095 with rst_i=1 after the 3rd handshake -> cmd_valid_o=0 and req_ready_o=1 the cycle after reset, with no further commands.

Source files
------------

// File: rtl/rpc_ctrl_pkg.sv
// Shared types and default widths for the RPC DRAM controller front end.
// Burst requests arriving from upstream are described by burst_req_t.
package rpc_ctrl_pkg;

    localparam int DEF_ALIGN_POS  = 5;
    localparam int DEF_ADDR_WIDTH = 20;
    localparam int DEF_LEN_WIDTH  = 12;

    typedef struct packed {
        logic                      is_write;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_LEN_WIDTH-1:0]  len;
    } burst_req_t;

endpackage

// File: rtl/rpc_burst_splitter.sv
// Splits an upstream DRAM burst into commands that never cross a
// 2^DRAM_ALIGN_POS word block, issuing one command per handshake.
module rpc_burst_splitter
    import rpc_ctrl_pkg::*;
#(
    parameter int DRAM_ALIGN_POS  = DEF_ALIGN_POS,
    parameter int DRAM_ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int REQ_LEN_WIDTH   = DEF_LEN_WIDTH
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic                       req_is_write_i,
    input  logic [DRAM_ADDR_WIDTH-1:0] req_addr_i,
    input  logic [REQ_LEN_WIDTH-1:0]   req_len_i,
    output logic                       cmd_valid_o,
    input  logic                       cmd_ready_i,
    output logic                       cmd_is_write_o,
    output logic [DRAM_ALIGN_POS-1:0]  cmd_len_o,
    output logic [DRAM_ADDR_WIDTH-1:0] cmd_addr_o,
    output logic                       cmd_last_o,
    output logic                       busy_o
);

    // Remaining-word counter holds len+1, so it needs one extra bit.
    localparam int RW = REQ_LEN_WIDTH + 1;
    // Chunk arithmetic width: wide enough for both the counter and a full block.
    localparam int CW = (RW > DRAM_ALIGN_POS + 1) ? RW : DRAM_ALIGN_POS + 1;
    localparam logic [CW-1:0] BLK = CW'(2 ** DRAM_ALIGN_POS);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t                     state_q;
    state_t                     state_d;
    logic [DRAM_ADDR_WIDTH-1:0] addr_q;
    logic [RW-1:0]              rem_q;
    logic                       wr_q;

    logic [CW-1:0]              room;
    logic [CW-1:0]              rem_ext;
    logic [CW-1:0]              chunk;
    logic                       chunk_last;
    logic                       accept;
    logic                       handshake;

    // Chunk = min(remaining words, words left in the current aligned block).
    always_comb begin
        room       = BLK - CW'(addr_q[DRAM_ALIGN_POS-1:0]);
        rem_ext    = CW'(rem_q);
        chunk      = (rem_ext < room) ? rem_ext : room;
        chunk_last = (rem_ext == chunk);
    end

    assign accept    = (state_q == IDLE) && req_valid_i;
    assign handshake = (state_q == ISSUE) && cmd_ready_i;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and handshake/status outputs.
    always_comb begin
        state_d     = state_q;
        req_ready_o = 1'b0;
        busy_o      = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                busy_o = 1'b1;
                if (cmd_ready_i && chunk_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Burst context: loaded on accept, advanced one chunk per handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q <= '0;
            rem_q  <= '0;
            wr_q   <= 1'b0;
        end else if (accept) begin
            addr_q <= req_addr_i;
            rem_q  <= RW'(req_len_i) + RW'(1);
            wr_q   <= req_is_write_i;
        end else if (handshake) begin
            addr_q <= addr_q + DRAM_ADDR_WIDTH'(chunk);
            rem_q  <= rem_q - RW'(chunk);
        end
    end

    // Command fields come only from state and registers, never cmd_ready_i.
    always_comb begin
        cmd_valid_o    = busy_o;
        cmd_addr_o     = addr_q;
        cmd_is_write_o = wr_q;
        cmd_len_o      = '0;
        cmd_last_o     = 1'b0;
        if (busy_o) begin
            cmd_len_o  = DRAM_ALIGN_POS'(chunk - CW'(1));
            cmd_last_o = chunk_last;
        end
    end

endmodule
